// File: rtl/srff_driver.sv
// Sequenced set/reset pulse driver for an external cross-coupled NOR SR latch.
// Issues a dead gap and then a fixed-width s or r pulse, and confirms the result through synchronised q.
module srff_driver #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 2,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_val,
  output logic s,
  output logic r,
  input  logic q,
  output logic level,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [7:0] GapLoad     = 8'(GAP_W - 1);
  localparam logic [7:0] PulseLoad   = 8'(PULSE_W - 1);
  localparam logic [7:0] TimeoutLoad = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGap, StPulse, StCheck} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tgt_q, tgt_d;
  logic       s_q, s_d, r_q, r_d;
  logic       done_q, done_d, err_q, err_d;
  logic       sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      tgt_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sync1_q <= q;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StGap;
          tgt_d   = req_val;
          cnt_d   = GapLoad;
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          state_d = StPulse;
          cnt_d   = PulseLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StPulse: begin
        if (cnt_q == 8'd0) begin
          state_d = StCheck;
          cnt_d   = TimeoutLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StCheck: begin
        if (sync2_q == tgt_q) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
    // Drives follow the next state so the pulse edges coincide with state changes.
    s_d = (state_d == StPulse) && tgt_d;
    r_d = (state_d == StPulse) && !tgt_d;
  end

  assign s         = s_q;
  assign r         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign level     = sync2_q;
  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_srff_driver.sv
// Directed bench for srff_driver: default instance on an ideal latch model with a stuck-q option,
// plus a minimum-timing instance (PULSE_W=1, GAP_W=1, TIMEOUT=3).
module tb_srff_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_val = 1'b0, req_ready;
  logic s, r, q, level, busy, done, err;
  logic req_valid_sm = 1'b0, req_val_sm = 1'b0, req_ready_sm;
  logic s_sm, r_sm, q_sm, level_sm, busy_sm, done_sm, err_sm;
  logic lq = 1'b0, lq_sm = 1'b0, stuck = 1'b0, overlap = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  // Ideal SR latch behaviour; q is optionally stuck at 0.
  always @(s or r) begin
    if (s && !r) lq = 1'b1;
    else if (r && !s) lq = 1'b0;
  end
  always @(s_sm or r_sm) begin
    if (s_sm && !r_sm) lq_sm = 1'b1;
    else if (r_sm && !s_sm) lq_sm = 1'b0;
  end
  assign q    = stuck ? 1'b0 : lq;
  assign q_sm = lq_sm;

  always @(negedge clk) if ((s && r) || (s_sm && r_sm)) overlap = 1'b1;

  srff_driver dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_val(req_val),
    .s(s), .r(r), .q(q), .level(level), .busy(busy), .done(done), .err(err)
  );

  srff_driver #(.PULSE_W(1), .GAP_W(1), .TIMEOUT(3)) dut_sm (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_sm), .req_ready(req_ready_sm),
    .req_val(req_val_sm), .s(s_sm), .r(r_sm), .q(q_sm), .level(level_sm), .busy(busy_sm),
    .done(done_sm), .err(err_sm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cyc(input string tn, input int k, input logic es, input logic er,
                         input logic ed, input logic ee);
    chk($sformatf("%s s k=%0d", tn, k), 32'(s), 32'(es));
    chk($sformatf("%s r k=%0d", tn, k), 32'(r), 32'(er));
    chk($sformatf("%s done k=%0d", tn, k), 32'(done), 32'(ed));
    chk($sformatf("%s err k=%0d", tn, k), 32'(err), 32'(ee));
  endtask

  // Accept one command; afterwards the bench sits in cycle 1 of that command.
  task automatic accept(input logic v);
    req_valid = 1'b1;
    req_val   = v;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst s", 32'(s), 32'd0);
    chk("rst r", 32'(r), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst level", 32'(level), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();

    // Set from q=0 with the default timing.
    accept(1'b1);
    for (int k = 1; k <= 9; k++) begin
      chk_cyc("t1", k, (k >= 3 && k <= 6), 1'b0, (k == 8), 1'b0);
      if (k == 8) begin
        chk("t1 level", 32'(level), 32'd1);
        chk("t1 req_ready", 32'(req_ready), 32'd1);
      end
      if (k == 7) chk("t1 busy in check", 32'(busy), 32'd1);
      step();
    end

    // Redundant set: latch already 1, the full sequence still runs.
    accept(1'b1);
    for (int k = 1; k <= 9; k++) begin
      chk_cyc("t4", k, (k >= 3 && k <= 6), 1'b0, (k == 8), 1'b0);
      step();
    end

    // Reset command, then a set accepted in its done cycle.
    accept(1'b0);
    for (int k = 1; k <= 17; k++) begin
      chk_cyc("t2", k, (k >= 11 && k <= 14), (k >= 3 && k <= 6), (k == 8 || k == 16), 1'b0);
      if (k == 8) begin
        req_valid = 1'b1;
        req_val   = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    chk("t2 level", 32'(level), 32'd1);

    // Stuck latch: q never follows, timeout expected.
    stuck = 1'b1;
    step(); step(); step();
    chk("t3 level pre", 32'(level), 32'd0);
    accept(1'b1);
    for (int k = 1; k <= 16; k++) begin
      chk_cyc("t3", k, (k >= 3 && k <= 6), 1'b0, 1'b0, (k == 15));
      if (k == 14) chk("t3 busy", 32'(busy), 32'd1);
      if (k == 15) chk("t3 req_ready", 32'(req_ready), 32'd1);
      step();
    end
    stuck = 1'b0;
    step(); step(); step();

    // Asynchronous reset mid-pulse.
    accept(1'b1);
    step(); step(); step();
    chk("t5 s before rst", 32'(s), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5 s async", 32'(s), 32'd0);
    chk("t5 busy async", 32'(busy), 32'd0);
    step(); step();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("t5 done k=%0d", k), 32'(done), 32'd0);
      chk($sformatf("t5 err k=%0d", k), 32'(err), 32'd0);
      chk($sformatf("t5 busy k=%0d", k), 32'(busy), 32'd0);
      chk($sformatf("t5 req_ready k=%0d", k), 32'(req_ready), 32'd1);
    end

    // req_valid held high while req_val toggles; only IDLE edges capture.
    req_valid = 1'b1;
    req_val   = 1'b1;
    step();
    for (int k = 1; k <= 17; k++) begin
      chk_cyc("t6", k, (k >= 3 && k <= 6), (k >= 11 && k <= 14), (k == 8 || k == 16), 1'b0);
      if (k == 9) chk("t6 req_ready", 32'(req_ready), 32'd0);
      if (k == 8) req_val = 1'b0;
      else req_val = k[0];
      if (k == 16) req_valid = 1'b0;
      step();
    end
    chk("t6 idle after", 32'(busy), 32'd0);

    // Minimum timing instance.
    req_valid_sm = 1'b1;
    req_val_sm   = 1'b1;
    step();
    req_valid_sm = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("sm s k=%0d", k), 32'(s_sm), 32'(k == 2));
      chk($sformatf("sm r k=%0d", k), 32'(r_sm), 32'd0);
      chk($sformatf("sm done k=%0d", k), 32'(done_sm), 32'(k == 5));
      chk($sformatf("sm err k=%0d", k), 32'(err_sm), 32'd0);
      step();
    end

    chk("s and r overlap", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/srff_driver.md
Name: srff_driver

Overview:
Sequenced driver for an external cross-coupled NOR SR latch. It accepts a one-bit target-level command over a valid/ready handshake and generates non-overlapping, fixed-width set or reset pulses on s/r. It then reads the latch's q output back through a 2-flop synchroniser and reports completion or timeout. It sits between synchronous control logic and latch-based storage or indicator cells.

Parameters:
PULSE_W, 4, cycles s or r is held high per command (legal 1..255)
GAP_W, 2, dead cycles with s=r=0 before each pulse (legal 1..255)
TIMEOUT, 8, max CHECK cycles waiting for q to match the target (legal 3..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  command valid
req_ready  output  1  driver can accept a command (high only in IDLE)
req_val  input  1  target latch level: 1 = set, 0 = reset
s  output  1  set drive to latch, registered
r  output  1  reset drive to latch, registered
q  input  1  latch q feedback, asynchronous to clk
level  output  1  synchronised q (second sync flop)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse: latch reached target
err  output  1  one-cycle pulse: timeout, latch did not reach target

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0): s=0, r=0, done=0, err=0, busy=0, req_ready=1, sync flops=0, level=0, state=IDLE, all counters 0. On assertion in mid-operation, s and r drop to 0 immediately (asynchronous) and any command in flight is discarded without done or err.
- All outputs are registered except req_ready and busy, which are decoded from the state register.
- Invariant: s and r are never both 1 in any cycle, including across back-to-back commands.
- FSM states: IDLE, GAP, PULSE, CHECK.
  - IDLE: req_ready=1. When req_valid=1 at an edge, capture tgt=req_val, load cnt=GAP_W-1, and go to GAP. req_val is ignored when no transfer occurs.
  - GAP: s=r=0 for exactly GAP_W cycles. At cnt=0, load cnt=PULSE_W-1 and go to PULSE.
  - PULSE: s=tgt, r=~tgt for exactly PULSE_W cycles. At cnt=0, load cnt=TIMEOUT-1 and go to CHECK. The s/r registers are updated on the same edges as the state change, so the pulse width is exact.
  - CHECK: s=r=0. If level==tgt, go to IDLE and set done=1 for the next cycle. Else if cnt=0, go to IDLE and set err=1 for the next cycle. Else decrement cnt.
- A pulse is always issued, even if level already equals tgt. This makes timing deterministic.
- done and err are never high together. The cycle in which done or err is high is already IDLE, with req_ready=1. A new command accepted in that cycle starts normally.
- Timing for an accept edge at cycle 0: GAP covers cycles 1..GAP_W; the pulse covers cycles GAP_W+1..GAP_W+PULSE_W; the first CHECK cycle is GAP_W+PULSE_W+1. With defaults: pulse in cycles 3..6, first CHECK in cycle 7.
- Synchroniser latency is 2 cycles: a change on q is visible on level 2 edges later.
- Counters are 8 bits wide, and parameters never wrap them.

Test Plan:
1. Defaults, ideal latch model (SR NOR pair on s/r/q), q=0 at start; req_val=1 accepted at cycle 0 -> s=1 for cycles 3..6, r=0 throughout; done=1 in cycle 8 only; err=0; level=1; req_ready=1 from cycle 8.
2. Back-to-back: set accepted in the done cycle of a previous reset command -> at least 2 dead cycles between r falling and s rising; s&r never 1 in any cycle (assertion enabled for the whole run).
3. Stuck latch (q tied 0), req_val=1 -> pulse as in test 1; CHECK for cycles 7..14; err=1 in cycle 15 only; done never asserted.
4. Redundant command: q=1 already, req_val=1 -> full GAP and PULSE still issued; done in cycle 8.
5. rst_n driven low during cycle 4 (mid-pulse) -> s drops to 0 without waiting for a clock edge; after release req_ready=1, busy=0; no done or err for the aborted command.
6. Handshake: req_valid held high with req_val toggling during busy -> no capture until IDLE; exactly one transfer per IDLE cycle with req_valid=1; PULSE_W=1, GAP_W=1, TIMEOUT=3 run gives s high for exactly 1 cycle.
